// File: rtl/ps2_text_cursor.sv
// rtl/ps2_text_cursor.sv - PS/2 ASCII text-entry cursor and character-buffer writer
//
// Purpose:
//   Consumes one ASCII code per rx_data_ready/rx_read handshake from
//   ps2_keyboard. Printable codes go to the character buffer write port.
//   Backspace, carriage return and ESC (clear screen) are also handled.
//   The cursor is tracked as a character cell, and its pixel origin is
//   driven to VGA_Pattern.
//
// Ports:
//   clk            in   system clock (CLOCK_50)
//   reset          in   asynchronous, active-high reset
//   rx_ascii       in   [7:0] ASCII code from ps2_keyboard
//   rx_data_ready  in   level, high while a code is pending
//   rx_read        out  one-cycle acknowledge of rx_ascii
//   wr_en          out  character-buffer write strobe
//   wr_addr        out  [ADDR_W-1:0] buffer address, row*COLS + col
//   wr_data        out  [7:0] character to write
//   cur_col        out  [3:0] cursor column
//   cur_row        out  [3:0] cursor row
//   cur_x          out  [9:0] cur_col*CELL_W
//   cur_y          out  [9:0] cur_row*CELL_H
//   busy           out  high while executing a code or clearing the screen
//   cursor_vis     out  cursor visibility
//
// Configuration:
//   PS2_TEXT_CURSOR_BLINK_EN  when defined, cursor_vis toggles every
//                             BLINK_DIV cycles and restarts visible on
//                             every cursor move; otherwise it is tied to 1.

module ps2_text_cursor #(
   parameter int COLS      = 16,
   parameter int ROWS      = 12,
   parameter int CELL_W    = 40,
   parameter int CELL_H    = 40,
   parameter int ADDR_W    = 8,
   parameter int BLINK_DIV = 12500000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_ascii,
   input  logic              rx_data_ready,
   output logic              rx_read,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [3:0]        cur_col,
   output logic [3:0]        cur_row,
   output logic [9:0]        cur_x,
   output logic [9:0]        cur_y,
   output logic              busy,
   output logic              cursor_vis
);

   localparam logic [7:0]      ASCII_BS    = 8'h08;
   localparam logic [7:0]      ASCII_CR    = 8'h0D;
   localparam logic [7:0]      ASCII_ESC   = 8'h1B;
   localparam logic [7:0]      ASCII_SPACE = 8'h20;
   localparam logic [3:0]      LAST_COL    = 4'(COLS - 1);
   localparam logic [3:0]      LAST_ROW    = 4'(ROWS - 1);
   localparam logic [ADDR_W:0] CELLS       = (ADDR_W + 1)'(COLS * ROWS);
   localparam logic [ADDR_W:0] CNT_ONE     = (ADDR_W + 1)'(1);

   if (BLINK_DIV < 1 || (2 ** ADDR_W) < COLS * ROWS) begin : g_param_check
      $error("ps2_text_cursor: BLINK_DIV must be >= 1 and 2**ADDR_W >= COLS*ROWS");
   end

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      CLEAR
   } state_t;

   state_t            state;
   logic              armed;
   logic [7:0]        char_q;
   // One extra bit so the counter can reach COLS*ROWS, which marks that
   // the last write has already been presented on the port.
   logic [ADDR_W:0]   clr_cnt;

   logic              printable;
   logic              clr_done;
   logic [3:0]        row_inc;
   logic [3:0]        nxt_col;
   logic [3:0]        nxt_row;

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] r, input logic [3:0] c);
      return ADDR_W'(32'(r) * COLS + 32'(c));
   endfunction

   assign printable = (char_q >= 8'h20) && (char_q <= 8'h7E);
   assign clr_done  = (clr_cnt == CELLS);

   // Cursor position after the current edge; cur_x/cur_y are derived from
   // this so they change on the same edge as cur_col/cur_row.
   always_comb begin
      nxt_col = cur_col;
      nxt_row = cur_row;
      row_inc = (cur_row == LAST_ROW) ? 4'd0 : cur_row + 4'd1;
      if (state == EXEC) begin
         if (printable) begin
            if (cur_col == LAST_COL) begin
               nxt_col = 4'd0;
               nxt_row = row_inc;
            end else begin
               nxt_col = cur_col + 4'd1;
            end
         end else if (char_q == ASCII_BS) begin
            // Backspace at the home cell stays put.
            if (cur_col != 4'd0) begin
               nxt_col = cur_col - 4'd1;
            end else if (cur_row != 4'd0) begin
               nxt_col = LAST_COL;
               nxt_row = cur_row - 4'd1;
            end
         end else if (char_q == ASCII_CR) begin
            nxt_col = 4'd0;
            nxt_row = row_inc;
         end
      end else if (state == CLEAR && clr_done) begin
         nxt_col = 4'd0;
         nxt_row = 4'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         armed   <= 1'b1;
         char_q  <= 8'h00;
         clr_cnt <= '0;
         rx_read <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= 8'h00;
         cur_col <= 4'd0;
         cur_row <= 4'd0;
         cur_x   <= 10'd0;
         cur_y   <= 10'd0;
         busy    <= 1'b0;
      end else begin
         // A held level is accepted once; the keyboard must drop ready
         // before the next code can be taken.
         if (!rx_data_ready) begin
            armed <= 1'b1;
         end

         cur_col <= nxt_col;
         cur_row <= nxt_row;
         cur_x   <= 10'(32'(nxt_col) * CELL_W);
         cur_y   <= 10'(32'(nxt_row) * CELL_H);

         case (state)
            IDLE: begin
               wr_en <= 1'b0;
               if (armed && rx_data_ready) begin
                  char_q  <= rx_ascii;
                  rx_read <= 1'b1;
                  armed   <= 1'b0;
                  busy    <= 1'b1;
                  state   <= EXEC;
               end
            end

            EXEC: begin
               rx_read <= 1'b0;
               wr_en   <= 1'b0;
               if (printable) begin
                  wr_en   <= 1'b1;
                  wr_addr <= cell_addr(cur_row, cur_col);
                  wr_data <= char_q;
               end else if (char_q == ASCII_BS) begin
                  wr_en   <= 1'b1;
                  wr_addr <= cell_addr(nxt_row, nxt_col);
                  wr_data <= ASCII_SPACE;
               end
               if (char_q == ASCII_ESC) begin
                  clr_cnt <= '0;
                  state   <= CLEAR;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            CLEAR: begin
               // Stay in CLEAR one cycle past the last write so every
               // write is presented while busy is still high.
               if (clr_done) begin
                  wr_en <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  wr_en   <= 1'b1;
                  wr_addr <= clr_cnt[ADDR_W-1:0];
                  wr_data <= ASCII_SPACE;
                  clr_cnt <= clr_cnt + CNT_ONE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef PS2_TEXT_CURSOR_BLINK_EN
   localparam int                CNT_W      = $clog2(BLINK_DIV + 1);
   localparam logic [CNT_W-1:0]  BLINK_LAST = CNT_W'(BLINK_DIV - 1);

   logic             moved;
   logic [CNT_W-1:0] blink_cnt;

   assign moved = (nxt_col != cur_col) || (nxt_row != cur_row);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt  <= '0;
         cursor_vis <= 1'b1;
      end else if (moved) begin
         blink_cnt  <= '0;
         cursor_vis <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt  <= '0;
         cursor_vis <= ~cursor_vis;
      end else begin
         blink_cnt <= blink_cnt + CNT_W'(1);
      end
   end
`else
   assign cursor_vis = 1'b1;
`endif

endmodule

// File: tb/tb_ps2_text_cursor.sv
// tb/tb_ps2_text_cursor.sv - self-checking bench for ps2_text_cursor

module tb_ps2_text_cursor;

   localparam int COLS  = 16;
   localparam int ROWS  = 12;
   localparam int CELLS = COLS * ROWS;

   logic       clk;
   logic       reset;
   logic [7:0] rx_ascii;
   logic       rx_data_ready;
   logic       rx_read;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] cur_col;
   logic [3:0] cur_row;
   logic [9:0] cur_x;
   logic [9:0] cur_y;
   logic       busy;
   logic       cursor_vis;

   int n_checks = 0;
   int n_fail   = 0;
   int rd_pulses = 0;
   int vis_low  = 0;

   logic [7:0] dut_buf [256];
   logic [7:0] m_buf [CELLS];
   int         m_pos;

   typedef struct {
      logic [7:0] code;
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
      logic [3:0] col;
      logic [3:0] row;
      logic [9:0] x;
      logic [9:0] y;
   } vec_t;

   vec_t vecs [13];

   ps2_text_cursor #(
      .COLS(16), .ROWS(12), .CELL_W(40), .CELL_H(40), .ADDR_W(8), .BLINK_DIV(4)
   ) dut (
      .clk(clk), .reset(reset), .rx_ascii(rx_ascii), .rx_data_ready(rx_data_ready),
      .rx_read(rx_read), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cur_col(cur_col), .cur_row(cur_row), .cur_x(cur_x), .cur_y(cur_y),
      .busy(busy), .cursor_vis(cursor_vis)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (rx_read) rd_pulses++;
         if (wr_en) dut_buf[wr_addr] = wr_data;
         if (cursor_vis !== 1'b1) vis_low++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_cursor(input string nm, input int col, input int row);
      check({nm, "_col"}, 32'(cur_col), col);
      check({nm, "_row"}, 32'(cur_row), row);
      check({nm, "_x"},   32'(cur_x),   col * 40);
      check({nm, "_y"},   32'(cur_y),   row * 40);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rx_data_ready = 1'b0;
      rx_ascii = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Presents one code, waits for its acknowledge, returns what the write
   // port shows in the cycle after the acknowledge, then waits for idle.
   task automatic send(input logic [7:0] c, output logic w, output logic [7:0] a, output logic [7:0] d);
      int n;
      rx_ascii = c;
      rx_data_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rx_read && n < 400);
      if (!rx_read) check("ack_timeout", 32'(rx_read), 1);
      rx_data_ready = 1'b0;
      @(negedge clk);
      w = wr_en;
      a = wr_addr;
      d = wr_data;
      n = 0;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("busy_timeout", 32'(busy), 0);
   endtask

   task automatic model_step(input logic [7:0] c, output logic ew, output logic [7:0] ea, output logic [7:0] ed);
      ew = 1'b0;
      ea = 8'h00;
      ed = 8'h00;
      if (c >= 8'h20 && c <= 8'h7E) begin
         ew = 1'b1;
         ea = 8'(m_pos);
         ed = c;
         m_buf[m_pos] = c;
         m_pos = (m_pos + 1) % CELLS;
      end else if (c == 8'h08) begin
         if (m_pos > 0) m_pos--;
         ew = 1'b1;
         ea = 8'(m_pos);
         ed = 8'h20;
         m_buf[m_pos] = 8'h20;
      end else if (c == 8'h0D) begin
         m_pos = ((m_pos / COLS + 1) % ROWS) * COLS;
      end else if (c == 8'h1B) begin
         for (int i = 0; i < CELLS; i++) m_buf[i] = 8'h20;
         m_pos = 0;
      end
   endtask

   initial begin
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
      logic       ew;
      logic [7:0] ea;
      logic [7:0] ed;
      logic [7:0] c;
      int         p0;
      int         n;
      int         errs;
      int         r;

      vecs[0]  = '{8'h41, 1'b1, 8'd0,  8'h41, 4'd1,  4'd0, 10'd40,  10'd0};
      vecs[1]  = '{8'h0D, 1'b0, 8'd0,  8'h00, 4'd0,  4'd1, 10'd0,   10'd40};
      vecs[2]  = '{8'h08, 1'b1, 8'd15, 8'h20, 4'd15, 4'd0, 10'd600, 10'd0};
      vecs[3]  = '{8'h7E, 1'b1, 8'd15, 8'h7E, 4'd0,  4'd1, 10'd0,   10'd40};
      vecs[4]  = '{8'h20, 1'b1, 8'd16, 8'h20, 4'd1,  4'd1, 10'd40,  10'd40};
      vecs[5]  = '{8'h07, 1'b0, 8'd0,  8'h00, 4'd1,  4'd1, 10'd40,  10'd40};
      vecs[6]  = '{8'h7F, 1'b0, 8'd0,  8'h00, 4'd1,  4'd1, 10'd40,  10'd40};
      vecs[7]  = '{8'h1F, 1'b0, 8'd0,  8'h00, 4'd1,  4'd1, 10'd40,  10'd40};
      vecs[8]  = '{8'h0A, 1'b0, 8'd0,  8'h00, 4'd1,  4'd1, 10'd40,  10'd40};
      vecs[9]  = '{8'h08, 1'b1, 8'd16, 8'h20, 4'd0,  4'd1, 10'd0,   10'd40};
      vecs[10] = '{8'h08, 1'b1, 8'd15, 8'h20, 4'd15, 4'd0, 10'd600, 10'd0};
      vecs[11] = '{8'h0D, 1'b0, 8'd0,  8'h00, 4'd0,  4'd1, 10'd0,   10'd40};
      vecs[12] = '{8'h0D, 1'b0, 8'd0,  8'h00, 4'd0,  4'd2, 10'd0,   10'd80};

      // Reset state
      reset = 1'b1;
      rx_data_ready = 1'b0;
      rx_ascii = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_in_ctrl", {rx_read, wr_en, wr_addr, wr_data, cur_col, cur_row}, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ctrl", {rx_read, wr_en, wr_addr, wr_data, cur_col, cur_row}, 0);
      check("rst_xy", {cur_x, cur_y}, 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_vis", 32'(cursor_vis), 1);

      // 0x41 with ready held for three cycles
      p0 = rd_pulses;
      rx_ascii = 8'h41;
      rx_data_ready = 1'b1;
      @(negedge clk);
      check("a_ack", 32'(rx_read), 1);
      check("a_busy", 32'(busy), 1);
      @(negedge clk);
      check("a_wr_en", 32'(wr_en), 1);
      check("a_wr_addr", 32'(wr_addr), 0);
      check("a_wr_data", 32'(wr_data), 8'h41);
      check("a_ack_low", 32'(rx_read), 0);
      check_cursor("a", 1, 0);
      @(negedge clk);
      rx_data_ready = 1'b0;
      repeat (4) @(negedge clk);
      check("a_pulses", rd_pulses - p0, 1);
      check("a_wr_idle", 32'(wr_en), 0);

      // Table-driven codes from the home cell
      do_reset();
      for (int i = 0; i < 13; i++) begin
         send(vecs[i].code, w, a, d);
         check($sformatf("vec%0d_wr", i), 32'(w), 32'(vecs[i].wr));
         if (vecs[i].wr) begin
            check($sformatf("vec%0d_addr", i), 32'(a), 32'(vecs[i].addr));
            check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].data));
         end
         check($sformatf("vec%0d_col", i), 32'(cur_col), 32'(vecs[i].col));
         check($sformatf("vec%0d_row", i), 32'(cur_row), 32'(vecs[i].row));
         check($sformatf("vec%0d_xy", i), {cur_x, cur_y}, {12'd0, vecs[i].x, vecs[i].y});
      end

      // Full row of printable codes, then CR on the last row
      do_reset();
      for (int i = 0; i < 16; i++) send(8'(8'h30 + i), w, a, d);
      check("row_last_addr", 32'(a), 15);
      check_cursor("row_wrap", 0, 1);
      for (int i = 0; i < 10; i++) send(8'h0D, w, a, d);
      for (int i = 0; i < 5; i++) send(8'h61, w, a, d);
      check_cursor("pre_cr", 5, 11);
      send(8'h0D, w, a, d);
      check_cursor("cr_wrap", 0, 0);

      // Backspace at home and across a row boundary
      send(8'h08, w, a, d);
      check("bs0_wr", {w, a, d}, {1'b1, 8'd0, 8'h20});
      check_cursor("bs0", 0, 0);
      for (int i = 0; i < 3; i++) send(8'h0D, w, a, d);
      send(8'h08, w, a, d);
      check("bs3_wr", {w, a, d}, {1'b1, 8'd47, 8'h20});
      check_cursor("bs3", 15, 2);

      // ESC with 0x42 pending during the clear
      rx_ascii = 8'h1B;
      rx_data_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rx_read && n < 50);
      check("esc_ack", 32'(rx_read), 1);
      rx_data_ready = 1'b0;
      @(negedge clk);
      p0 = rd_pulses;
      rx_ascii = 8'h42;
      rx_data_ready = 1'b1;
      n = 0;
      while (!wr_en && n < 10) begin
         @(negedge clk);
         n++;
      end
      errs = 0;
      for (int i = 0; i < CELLS; i++) begin
         if (wr_en !== 1'b1 || wr_addr !== 8'(i) || wr_data !== 8'h20 || busy !== 1'b1 || rx_read !== 1'b0)
            errs++;
         @(negedge clk);
      end
      check("clr_seq_errs", errs, 0);
      check("clr_end_wr", 32'(wr_en), 0);
      check("clr_end_busy", 32'(busy), 0);
      check_cursor("clr_end", 0, 0);
      check("clr_no_ack", rd_pulses - p0, 0);
      @(negedge clk);
      check("pend_ack", 32'(rx_read), 1);
      rx_data_ready = 1'b0;
      @(negedge clk);
      check("pend_wr", {wr_en, wr_addr, wr_data}, {1'b1, 8'd0, 8'h42});
      check_cursor("pend", 1, 0);
      repeat (2) @(negedge clk);

      // Reset in the middle of a clear
      send(8'h5A, w, a, d);
      rx_ascii = 8'h1B;
      rx_data_ready = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rx_read && n < 50);
      rx_data_ready = 1'b0;
      n = 0;
      while (!(wr_en && wr_addr == 8'd100) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("mid_addr100", {wr_en, wr_addr}, {1'b1, 8'd100});
      reset = 1'b1;
      #1;
      check("mid_wr_drop", 32'(wr_en), 0);
      check("mid_busy", 32'(busy), 0);
      check_cursor("mid", 0, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      send(8'h43, w, a, d);
      check("mid_after", {w, a, d}, {1'b1, 8'd0, 8'h43});

`ifdef PS2_TEXT_CURSOR_BLINK_EN
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check($sformatf("blink_k%0d", k), 32'(cursor_vis), ((k / 4) % 2 == 0) ? 1 : 0);
      end
`endif

      // Randomized codes against the reference model
      do_reset();
      for (int i = 0; i < 256; i++) dut_buf[i] = 8'h00;
      for (int i = 0; i < CELLS; i++) m_buf[i] = 8'h00;
      m_pos = 0;
      for (int it = 0; it < 160; it++) begin
         r = int'($urandom_range(0, 99));
         if (r < 68)      c = 8'($urandom_range(32, 126));
         else if (r < 80) c = 8'h08;
         else if (r < 90) c = 8'h0D;
         else if (r < 97) c = 8'($urandom_range(127, 255));
         else             c = 8'h1B;
         model_step(c, ew, ea, ed);
         send(c, w, a, d);
         check($sformatf("rnd%0d_wr", it), 32'(w), 32'(ew));
         if (ew) check($sformatf("rnd%0d_addr_data", it), {a, d}, {ea, ed});
         check($sformatf("rnd%0d_pos", it), {cur_col, cur_row, cur_x, cur_y},
               {4'(m_pos % COLS), 4'(m_pos / COLS), 10'((m_pos % COLS) * 40), 10'((m_pos / COLS) * 40)});
      end
      errs = 0;
      for (int i = 0; i < CELLS; i++) if (dut_buf[i] !== m_buf[i]) errs++;
      check("buf_cells_wrong", errs, 0);

`ifndef PS2_TEXT_CURSOR_BLINK_EN
      check("vis_low_cycles", vis_low, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
